// File: rtl/lapido_pkg.sv
// Shared encodings for the Lapido multi-cycle sequencer.
// Optional illegal-opcode trap: LAPIDO_ILLEGAL_TRAP_EN.
package lapido_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [2:0] CLS_ALU   = 3'b001;
    localparam logic [2:0] CLS_MEM   = 3'b100;
    localparam logic [2:0] CLS_CONST = 3'b010;
    localparam logic [2:0] CLS_NOP   = 3'b000;

    localparam logic [1:0] LOADLIT_SUB = 2'b10;

    function automatic logic [2:0] op_class(input logic [7:0] op);
        return op[7:5];
    endfunction

endpackage

// File: rtl/lapido_ack_timer.sv
// Saturating wait counter for memory handshakes.
// Flags timeout on the cycle the count would reach ACK_TIMEOUT.
module lapido_ack_timer
    import lapido_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count waiting cycles; clear has priority, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/lapido_sequencer.sv
// Lapido multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional HALT on illegal opcode class: LAPIDO_ILLEGAL_TRAP_EN.
module lapido_sequencer
    import lapido_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_addr_sel,
    output logic       mem_read_n,
    output logic       mem_write_n,
    output logic       ir_load,
    output logic       pc_enable,
    output logic       alu_latch,
    output logic       reg_write,
    output logic       bus_error,
    output logic       halted,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;

    logic       ack;
    logic       active;
    logic       tmo;
    logic       abort;
    logic [2:0] cls;
    logic       is_mem;
    logic       is_store;
    logic       is_exec;
    logic       is_ill;
    logic       unused_op;

    assign ack      = mem_ack & reset_n;
    assign active   = (state_q == S_FETCH) || (state_q == S_MEMORY);
    assign abort    = tmo & ~ack;
    assign cls      = op_class(opcode);
    assign is_mem   = (cls == CLS_MEM);
    assign is_store = is_mem & opcode[0];
    assign is_exec  = (cls == CLS_ALU) || is_mem
                    || ((cls == CLS_CONST) && (opcode[1:0] == LOADLIT_SUB));
    assign is_ill   = !((cls == CLS_ALU) || is_mem
                    || (cls == CLS_CONST) || (cls == CLS_NOP));
    assign unused_op = ^opcode[4:2];
    assign state    = state_q;

    lapido_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (active),
        .clr     (~active | ack | tmo),
        .timeout (tmo)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle enables; reset forces the bus idle at once.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_read_n   = 1'b1;
        mem_write_n  = 1'b1;
        ir_load      = 1'b0;
        pc_enable    = 1'b0;
        alu_latch    = 1'b0;
        reg_write    = 1'b0;
        bus_error    = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = ~abort;
                mem_read_n = abort;
                if (ack) begin
                    ir_load   = 1'b1;
                    pc_enable = 1'b1;
                    state_d   = S_DECODE;
                end else if (tmo) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_exec) begin
                    state_d = S_EXECUTE;
                end else if (is_ill) begin
`ifdef LAPIDO_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_latch = 1'b1;
                state_d   = is_mem ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_req      = ~abort;
                mem_addr_sel = 1'b1;
                mem_read_n   = abort | is_store;
                mem_write_n  = abort | ~is_store;
                if (ack) begin
                    state_d = is_store ? S_FETCH : S_WRITEBACK;
                end else if (tmo) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
`ifdef LAPIDO_ILLEGAL_TRAP_EN
                halted  = 1'b1;
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (!reset_n) begin
            mem_req      = 1'b0;
            mem_addr_sel = 1'b0;
            mem_read_n   = 1'b1;
            mem_write_n  = 1'b1;
            ir_load      = 1'b0;
            pc_enable    = 1'b0;
            bus_error    = 1'b0;
        end
    end

endmodule

// File: tb/tb_lapido_sequencer.sv
// Scoreboard bench for lapido_sequencer.
// Expected per-cycle vectors are queued; a negedge monitor checks them.
module tb_lapido_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_addr_sel, mem_read_n, mem_write_n;
    logic       ir_load, pc_enable, alu_latch, reg_write;
    logic       bus_error, halted;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      name;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    // flags: req sel rd_n wr_n ir pc alu rw berr halt
    localparam logic [9:0] RST  = 10'b0011_000000;
    localparam logic [9:0] FNA  = 10'b1001_000000;
    localparam logic [9:0] FACK = 10'b1001_110000;
    localparam logic [9:0] DEC  = 10'b0011_000000;
    localparam logic [9:0] EXE  = 10'b0011_001000;
    localparam logic [9:0] MLD  = 10'b1101_000000;
    localparam logic [9:0] MST  = 10'b1110_000000;
    localparam logic [9:0] WB   = 10'b0011_000100;
    localparam logic [9:0] FTO  = 10'b0011_000010;
    localparam logic [9:0] MTO  = 10'b0111_000010;
    localparam logic [9:0] HLT  = 10'b0011_000001;

    lapido_sequencer #(
        .ACK_TIMEOUT (15),
        .CNT_W       (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_read_n   (mem_read_n),
        .mem_write_n  (mem_write_n),
        .ir_load      (ir_load),
        .pc_enable    (pc_enable),
        .alu_latch    (alu_latch),
        .reg_write    (reg_write),
        .bus_error    (bus_error),
        .halted       (halted),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic step(input string nm, input logic rst,
                        input logic [7:0] opc, input logic ack,
                        input logic [2:0] st, input logic [9:0] fl);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n = rst;
        opcode  = opc;
        mem_ack = ack;
        e.name = nm;
        e.v    = {st, fl};
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        logic [12:0] act;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {state, mem_req, mem_addr_sel, mem_read_n,
                       mem_write_n, ir_load, pc_enable, alu_latch,
                       reg_write, bus_error, halted};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s got=%b want=%b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        step("rst0", 0, 8'h00, 0, 3'd0, RST);
        step("rst_ack", 0, 8'h00, 1, 3'd0, RST);
        // NOP
        step("nop_f", 1, 8'h00, 1, 3'd0, FACK);
        step("nop_d", 1, 8'h00, 0, 3'd1, DEC);
        // ALU add
        step("alu_f", 1, 8'h20, 1, 3'd0, FACK);
        step("alu_d", 1, 8'h20, 0, 3'd1, DEC);
        step("alu_e", 1, 8'h20, 0, 3'd2, EXE);
        step("alu_wb", 1, 8'h20, 1, 3'd4, WB);
        // load, data ack delayed 3 cycles
        step("ld_f", 1, 8'h80, 1, 3'd0, FACK);
        step("ld_d", 1, 8'h80, 1, 3'd1, DEC);
        step("ld_e", 1, 8'h80, 0, 3'd2, EXE);
        for (int i = 0; i < 3; i++)
            step("ld_mwait", 1, 8'h80, 0, 3'd3, MLD);
        step("ld_mack", 1, 8'h80, 1, 3'd3, MLD);
        step("ld_wb", 1, 8'h80, 0, 3'd4, WB);
        // store
        step("st_f", 1, 8'h81, 1, 3'd0, FACK);
        step("st_d", 1, 8'h81, 0, 3'd1, DEC);
        step("st_e", 1, 8'h81, 0, 3'd2, EXE);
        step("st_mack", 1, 8'h81, 1, 3'd3, MST);
        // loadlit and non-loadlit constant
        step("lit_f", 1, 8'h42, 1, 3'd0, FACK);
        step("lit_d", 1, 8'h42, 0, 3'd1, DEC);
        step("lit_e", 1, 8'h42, 0, 3'd2, EXE);
        step("lit_wb", 1, 8'h42, 0, 3'd4, WB);
        step("cst_f", 1, 8'h40, 1, 3'd0, FACK);
        step("cst_d", 1, 8'h40, 0, 3'd1, DEC);
        // fetch timeout on cycle 15
        for (int i = 0; i < 14; i++)
            step("fto_wait", 1, 8'h00, 0, 3'd0, FNA);
        step("fto_err", 1, 8'h00, 0, 3'd0, FTO);
        step("fto_rst_f", 1, 8'h00, 1, 3'd0, FACK);
        step("fto_rst_d", 1, 8'h00, 0, 3'd1, DEC);
        // ack on cycle 15 wins
        for (int i = 0; i < 14; i++)
            step("f15_wait", 1, 8'h00, 0, 3'd0, FNA);
        step("f15_ack", 1, 8'h00, 1, 3'd0, FACK);
        step("f15_d", 1, 8'h00, 0, 3'd1, DEC);
        // memory timeout
        step("mto_f", 1, 8'h80, 1, 3'd0, FACK);
        step("mto_d", 1, 8'h80, 0, 3'd1, DEC);
        step("mto_e", 1, 8'h80, 0, 3'd2, EXE);
        for (int i = 0; i < 14; i++)
            step("mto_wait", 1, 8'h80, 0, 3'd3, MLD);
        step("mto_err", 1, 8'h80, 0, 3'd3, MTO);
        step("mto_f2", 1, 8'h00, 1, 3'd0, FACK);
        step("mto_d2", 1, 8'h00, 0, 3'd1, DEC);
        // illegal class
        step("ill_f", 1, 8'hE0, 1, 3'd0, FACK);
        step("ill_d", 1, 8'hE0, 0, 3'd1, DEC);
`ifdef LAPIDO_ILLEGAL_TRAP_EN
        step("halt0", 1, 8'hE0, 1, 3'd5, HLT);
        step("halt1", 1, 8'h00, 1, 3'd5, HLT);
        step("halt_rst", 0, 8'h00, 0, 3'd0, RST);
        step("halt_out", 1, 8'h00, 0, 3'd0, FNA);
`else
        step("ill_nop", 1, 8'h00, 0, 3'd0, FNA);
`endif
        // reset in the middle of a data access
        step("mr_f", 1, 8'h80, 1, 3'd0, FACK);
        step("mr_d", 1, 8'h80, 0, 3'd1, DEC);
        step("mr_e", 1, 8'h80, 0, 3'd2, EXE);
        step("mr_m", 1, 8'h80, 0, 3'd3, MLD);
        step("mr_rst", 0, 8'h80, 0, 3'd0, RST);
        step("mr_late_ack", 0, 8'h80, 1, 3'd0, RST);
        step("mr_rel", 1, 8'h00, 0, 3'd0, FNA);
        step("mr_f2", 1, 8'h00, 1, 3'd0, FACK);
        step("mr_d2", 1, 8'h00, 0, 3'd1, DEC);
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
